// File: rtl/imu_frame_ctrl.sv
// IMU frame sequencer: assembles 11-byte frames (0x55, type, 8 data bytes, checksum)
// from a UART byte stream, validates them and publishes the decoded words.
module imu_frame_ctrl #(
    parameter int TIMEOUT_CYC = 25000,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic [47:0]      acc,
    output logic [47:0]      gyro,
    output logic [47:0]      angle,
    output logic [15:0]      temp,
    output logic             acc_vld,
    output logic             gyro_vld,
    output logic             angle_vld,
    output logic             frame_err,
    output logic             timeout_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    localparam int         TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_HUNT, S_TYPE, S_DATA, S_SUM} state_t;

    state_t          state;
    logic [7:0]      ftype;
    logic [7:0]      sum;
    logic [2:0]      idx;
    logic [TW-1:0]   tcnt;
    logic [7:0]      dbuf [8];

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Payload buffer is pure data: no reset needed, only read after a full frame.
    always_ff @(posedge clk) begin
        if (rx_valid && state == S_DATA)
            dbuf[idx] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            ftype       <= 8'h00;
            sum         <= 8'h00;
            idx         <= 3'd0;
            tcnt        <= '0;
            acc         <= '0;
            gyro        <= '0;
            angle       <= '0;
            temp        <= '0;
            acc_vld     <= 1'b0;
            gyro_vld    <= 1'b0;
            angle_vld   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            err_cnt     <= '0;
            busy        <= 1'b0;
        end else begin
            acc_vld     <= 1'b0;
            gyro_vld    <= 1'b0;
            angle_vld   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (rx_valid) begin
                tcnt <= '0;
                case (state)
                    S_HUNT: begin
                        if (rx_byte == 8'h55) begin
                            state <= S_TYPE;
                            sum   <= 8'h55;
                            busy  <= 1'b1;
                        end
                    end
                    S_TYPE: begin
                        if (rx_byte == 8'h51 || rx_byte == 8'h52 || rx_byte == 8'h53) begin
                            ftype <= rx_byte;
                            sum   <= sum + rx_byte;
                            idx   <= 3'd0;
                            state <= S_DATA;
                        end else if (rx_byte == 8'h55) begin
                            sum <= 8'h55;
                        end else begin
                            state <= S_HUNT;
                            busy  <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        sum <= sum + rx_byte;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= S_SUM;
                    end
                    default: begin
                        state <= S_HUNT;
                        busy  <= 1'b0;
                        if (rx_byte == sum) begin
                            temp <= {dbuf[7], dbuf[6]};
                            case (ftype)
                                8'h51: begin
                                    acc     <= {dbuf[5], dbuf[4], dbuf[3], dbuf[2], dbuf[1], dbuf[0]};
                                    acc_vld <= 1'b1;
                                end
                                8'h52: begin
                                    gyro     <= {dbuf[5], dbuf[4], dbuf[3], dbuf[2], dbuf[1], dbuf[0]};
                                    gyro_vld <= 1'b1;
                                end
                                default: begin
                                    angle     <= {dbuf[5], dbuf[4], dbuf[3], dbuf[2], dbuf[1], dbuf[0]};
                                    angle_vld <= 1'b1;
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                        end
                    end
                endcase
            end else if (state != S_HUNT) begin
                // A byte arriving in the expiry cycle takes the branch above instead.
                if (tcnt == TCNT_LAST) begin
                    state       <= S_HUNT;
                    busy        <= 1'b0;
                    tcnt        <= '0;
                    timeout_err <= 1'b1;
                    err_cnt     <= sat_inc(err_cnt);
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imu_frame_ctrl.sv
// Bench for imu_frame_ctrl: directed scenarios plus randomized byte streams
// checked against a queue-based frame model.
module tb_imu_frame_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [47:0] acc, gyro, angle;
    logic [15:0] temp;
    logic        acc_vld, gyro_vld, angle_vld, frame_err, timeout_err, busy;
    logic [7:0]  err_cnt;

    imu_frame_ctrl #(.TIMEOUT_CYC(TO), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .acc(acc), .gyro(gyro), .angle(angle), .temp(temp),
        .acc_vld(acc_vld), .gyro_vld(gyro_vld), .angle_vld(angle_vld),
        .frame_err(frame_err), .timeout_err(timeout_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0]  mq[$];
    int          m_idle = 0;
    logic [47:0] m_acc = '0, m_gyro = '0, m_angle = '0;
    logic [15:0] m_temp = '0;
    int          m_err = 0;
    int          m_nacc = 0, m_ngyro = 0, m_nangle = 0, m_nferr = 0, m_nterr = 0;

    // Observed pulse counts
    int o_nacc = 0, o_ngyro = 0, o_nangle = 0, o_nferr = 0, o_nterr = 0, o_both = 0;

    always @(negedge clk) begin
        if (acc_vld) o_nacc++;
        if (gyro_vld) o_ngyro++;
        if (angle_vld) o_nangle++;
        if (frame_err) o_nferr++;
        if (timeout_err) o_nterr++;
        if (frame_err && timeout_err) o_both++;
    end

    task automatic m_reset();
        mq.delete();
        m_idle = 0;
        m_acc = '0; m_gyro = '0; m_angle = '0; m_temp = '0;
        m_err = 0;
    endtask

    task automatic m_frame_done();
        int s = 0;
        for (int i = 0; i < 10; i++) s += mq[i];
        if (s % 256 == int'(mq[10])) begin
            m_temp = {mq[9], mq[8]};
            if (mq[1] == 8'h51) begin m_acc = {mq[7], mq[6], mq[5], mq[4], mq[3], mq[2]}; m_nacc++; end
            else if (mq[1] == 8'h52) begin m_gyro = {mq[7], mq[6], mq[5], mq[4], mq[3], mq[2]}; m_ngyro++; end
            else begin m_angle = {mq[7], mq[6], mq[5], mq[4], mq[3], mq[2]}; m_nangle++; end
        end else begin
            m_nferr++;
            if (m_err < 255) m_err++;
        end
        mq.delete();
    endtask

    task automatic m_step(input logic v, input logic [7:0] b);
        if (v) begin
            m_idle = 0;
            if (mq.size() == 0) begin
                if (b == 8'h55) mq.push_back(b);
            end else if (mq.size() == 1) begin
                if (b == 8'h51 || b == 8'h52 || b == 8'h53) mq.push_back(b);
                else if (b != 8'h55) mq.delete();
            end else begin
                mq.push_back(b);
                if (mq.size() == 11) m_frame_done();
            end
        end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_nterr++;
                if (m_err < 255) m_err++;
                mq.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_byte  = b;
        @(posedge clk);
        m_step(v, b);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] cks_of(input logic [7:0] t, input logic [63:0] d);
        int s = 8'h55 + t;
        for (int i = 0; i < 8; i++) s += d[8*i +: 8];
        return 8'(s);
    endfunction

    task automatic send_frame(input logic [7:0] t, input logic [63:0] d, input logic good, input int gap);
        logic [7:0] c = cks_of(t, d);
        step(1'b1, 8'h55);
        repeat (gap) step(1'b0, 8'h00);
        step(1'b1, t);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) step(1'b0, 8'h00);
            step(1'b1, d[8*i +: 8]);
        end
        repeat (gap) step(1'b0, 8'h00);
        step(1'b1, good ? c : c ^ 8'h01);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({acc, gyro, angle, temp, err_cnt, busy, acc_vld, gyro_vld, angle_vld, frame_err, timeout_err} !== '0)
            $display("FAIL reset_outputs: got acc=%h gyro=%h angle=%h temp=%h err=%0d busy=%b, want all 0",
                     acc, gyro, angle, temp, err_cnt, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00);
        n_checks++;
        if (busy !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL reset_release: got busy=%b err=%0d, want 0/0", busy, err_cnt);
        else n_pass++;
    endtask

    task automatic test_accel_frame();
        send_frame(8'h51, 64'h0B40_0030_0020_0010, 1'b1, 0);
        n_checks++;
        if (acc_vld !== 1'b1 || acc !== 48'h0030_0020_0010 || temp !== 16'h0B40 || err_cnt !== 8'd0)
            $display("FAIL accel_frame: got vld=%b acc=%h temp=%h err=%0d, want 1/003000200010/0b40/0",
                     acc_vld, acc, temp, err_cnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL accel_busy_end: got %b want 0", busy);
        else n_pass++;
        step(1'b0, 8'h00);
        n_checks++;
        if (acc_vld !== 1'b0 || o_nacc != 1)
            $display("FAIL accel_single_pulse: got vld=%b count=%0d, want 0/1", acc_vld, o_nacc);
        else n_pass++;
    endtask

    task automatic test_gyro_frame();
        send_frame(8'h52, 64'h0000_8000_FFFF_0001, 1'b1, 1);
        n_checks++;
        if (gyro_vld !== 1'b1 || gyro !== 48'h8000_FFFF_0001 || temp !== 16'h0000)
            $display("FAIL gyro_frame: got vld=%b gyro=%h temp=%h, want 1/8000ffff0001/0000", gyro_vld, gyro, temp);
        else n_pass++;
        send_frame(8'h52, 64'h0000_8000_FFFF_0001, 1'b0, 0);
        n_checks++;
        if (frame_err !== 1'b1 || err_cnt !== 8'd1 || gyro_vld !== 1'b0 || gyro !== 48'h8000_FFFF_0001)
            $display("FAIL gyro_bad_cks: got ferr=%b err=%0d vld=%b gyro=%h, want 1/1/0/8000ffff0001",
                     frame_err, err_cnt, gyro_vld, gyro);
        else n_pass++;
    endtask

    task automatic test_resync();
        logic [63:0] d = {$urandom, $urandom};
        logic [7:0]  e0;
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h55);
        step(1'b1, 8'h55);
        step(1'b1, 8'h52);
        for (int i = 0; i < 8; i++) step(1'b1, d[8*i +: 8]);
        step(1'b1, cks_of(8'h52, d));
        n_checks++;
        if (gyro_vld !== 1'b1 || gyro !== d[47:0] || temp !== d[63:48])
            $display("FAIL resync_gyro: got vld=%b gyro=%h temp=%h, want 1/%h/%h", gyro_vld, gyro, temp, d[47:0], d[63:48]);
        else n_pass++;
        e0 = err_cnt;
        step(1'b1, 8'h55);
        step(1'b1, 8'h54);
        n_checks++;
        if (busy !== 1'b0 || err_cnt !== e0 || frame_err !== 1'b0)
            $display("FAIL bad_type: got busy=%b err=%0d ferr=%b, want 0/%0d/0", busy, err_cnt, frame_err, e0);
        else n_pass++;
        // Checksum byte that happens to be 0x55 must close the frame
        send_frame(8'h51, 64'h0000_0000_0000_00AF, 1'b1, 0);
        n_checks++;
        if (acc_vld !== 1'b1 || acc !== 48'h0000_0000_00AF || busy !== 1'b0)
            $display("FAIL cks_0x55: got vld=%b acc=%h busy=%b, want 1/0000000000af/0", acc_vld, acc, busy);
        else n_pass++;
        step(1'b1, 8'h51);
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL after_cks_0x55_hunt: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0]  e0 = err_cnt;
        logic [63:0] d;
        step(1'b1, 8'h55);
        step(1'b1, 8'h51);
        step(1'b1, 8'h02);
        repeat (TO - 1) step(1'b0, 8'h00);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL timeout_early: got terr=%b busy=%b, want 0/1", timeout_err, busy);
        else n_pass++;
        step(1'b0, 8'h00);
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || err_cnt !== e0 + 8'd1 || frame_err !== 1'b0)
            $display("FAIL timeout_expiry: got terr=%b busy=%b err=%0d ferr=%b, want 1/0/%0d/0",
                     timeout_err, busy, err_cnt, frame_err, e0 + 8'd1);
        else n_pass++;
        d = {$urandom, $urandom};
        send_frame(8'h51, d, 1'b1, 2);
        n_checks++;
        if (acc_vld !== 1'b1 || acc !== d[47:0])
            $display("FAIL after_timeout_frame: got vld=%b acc=%h, want 1/%h", acc_vld, acc, d[47:0]);
        else n_pass++;
        d[15:0] = 16'h0302;
        step(1'b1, 8'h55);
        step(1'b1, 8'h51);
        step(1'b1, 8'h02);
        repeat (TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h03);
        n_checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL byte_in_expiry: got terr=%b busy=%b, want 0/1", timeout_err, busy);
        else n_pass++;
        for (int i = 2; i < 8; i++) step(1'b1, d[8*i +: 8]);
        step(1'b1, cks_of(8'h51, d));
        n_checks++;
        if (acc_vld !== 1'b1 || acc !== d[47:0] || o_nterr != m_nterr)
            $display("FAIL expiry_frame_done: got vld=%b acc=%h nterr=%0d, want 1/%h/%0d",
                     acc_vld, acc, o_nterr, d[47:0], m_nterr);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            int          kind = $urandom_range(0, 9);
            logic [7:0]  t = 8'h51 + 8'($urandom_range(0, 2));
            logic [63:0] d = {$urandom, $urandom};
            if (kind < 5) send_frame(t, d, 1'b1, $urandom_range(0, 3));
            else if (kind < 7) send_frame(t, d, 1'b0, $urandom_range(0, 1));
            else if (kind < 9) step(1'b1, 8'($urandom));
            else begin
                int k = $urandom_range(0, 7);
                step(1'b1, 8'h55);
                step(1'b1, t);
                for (int i = 0; i < k; i++) step(1'b1, d[8*i +: 8]);
                repeat (TO) step(1'b0, 8'h00);
            end
            n_checks++;
            if (acc !== m_acc || gyro !== m_gyro || angle !== m_angle || temp !== m_temp)
                $display("FAIL rand_fields it=%0d: got %h %h %h %h, want %h %h %h %h",
                         it, acc, gyro, angle, temp, m_acc, m_gyro, m_angle, m_temp);
            else n_pass++;
            n_checks++;
            if (int'(err_cnt) != m_err || busy !== (mq.size() != 0))
                $display("FAIL rand_ctrl it=%0d: got err=%0d busy=%b, want %0d/%b", it, err_cnt, busy, m_err, mq.size() != 0);
            else n_pass++;
        end
        step(1'b0, 8'h00);
        n_checks++;
        if (o_nacc != m_nacc || o_ngyro != m_ngyro || o_nangle != m_nangle || o_nferr != m_nferr || o_nterr != m_nterr)
            $display("FAIL rand_pulse_counts: got %0d %0d %0d %0d %0d, want %0d %0d %0d %0d %0d",
                     o_nacc, o_ngyro, o_nangle, o_nferr, o_nterr, m_nacc, m_ngyro, m_nangle, m_nferr, m_nterr);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [63:0] d = 64'h1234_FFFE_8001_0100;
        step(1'b1, 8'h55);
        step(1'b1, 8'h53);
        step(1'b1, 8'h01);
        step(1'b1, 8'h02);
        step(1'b1, 8'h03);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc, gyro, angle, temp, err_cnt, busy, acc_vld, gyro_vld, angle_vld, frame_err, timeout_err} !== '0)
            $display("FAIL reset_midframe: got acc=%h gyro=%h angle=%h temp=%h err=%0d busy=%b, want all 0",
                     acc, gyro, angle, temp, err_cnt, busy);
        else n_pass++;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h53, d, 1'b1, 0);
        n_checks++;
        if (angle_vld !== 1'b1 || angle !== 48'hFFFE_8001_0100 || temp !== 16'h1234 || err_cnt !== 8'd0)
            $display("FAIL angle_after_reset: got vld=%b angle=%h temp=%h err=%0d, want 1/fffe80010100/1234/0",
                     angle_vld, angle, temp, err_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int n0 = o_nferr;
        for (int i = 0; i < 300; i++)
            send_frame(8'h51 + 8'($urandom_range(0, 2)), {$urandom, $urandom}, 1'b0, 0);
        step(1'b0, 8'h00);
        n_checks++;
        if (err_cnt !== 8'd255 || m_err != 255)
            $display("FAIL err_saturate: got %0d want 255", err_cnt);
        else n_pass++;
        n_checks++;
        if (o_nferr - n0 != 300)
            $display("FAIL ferr_pulse_count: got %0d want 300", o_nferr - n0);
        else n_pass++;
        n_checks++;
        if (o_both != 0)
            $display("FAIL err_overlap: got %0d overlapping cycles, want 0", o_both);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_accel_frame();
        test_gyro_frame();
        test_resync();
        test_timeout();
        test_random();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imu_frame_ctrl.md
Name: imu_frame_ctrl

Overview:
Sequencer that turns the byte stream from the UART receiver into validated 11-byte IMU frames and publishes them.
- Frame layout: 0x55 header, type byte, 8 data bytes, checksum.
- Frame types: 0x51 acceleration, 0x52 angular rate, 0x53 angle.
- Checks the checksum, enforces an inter-byte timeout, latches decoded fields per type and strobes a valid pulse.
- Sits between my_uart_rx-style byte receivers and downstream motion logic (threshold/alarm blocks).

Parameters:
- TIMEOUT_CYC, 25000, idle clk cycles allowed between bytes inside a frame (1 ms at 25 MHz); minimum 2.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per received byte
- acc  out  48  {z,y,x} signed 16-bit acceleration, from type 0x51
- gyro  out  48  {z,y,x} signed 16-bit angular rate, from type 0x52
- angle  out  48  {yaw,pitch,roll} signed 16-bit, from type 0x53
- temp  out  16  temperature word from the last good frame of any type
- acc_vld, gyro_vld, angle_vld  out  1 each  one-cycle pulse when the matching field updates
- frame_err  out  1  one-cycle pulse on checksum mismatch
- timeout_err  out  1  one-cycle pulse on inter-byte timeout
- err_cnt  out  ERR_W  saturating count of frame_err plus timeout_err events
- busy  out  1  high while a frame is in progress (state != HUNT)

Behaviour:
Clocking and reset:
- Single clock domain; all outputs registered.
- Reset: every output 0; state HUNT; byte index 0; running sum 0; timeout counter 0.

Byte order and checksum:
- Data bytes D0..D7 are little-endian pairs: xL xH yL yH zL zH TL TH.
- Word n = {D(2n+1), D(2n)}.
- Checksum = low 8 bits of the sum of bytes 0..9 (header, type, D0..D7). Accumulate modulo 256.

State machine (advances only on rx_valid=1):
- HUNT: byte 0x55 → TYPE, sum=0x55. Any other byte → stay in HUNT.
- TYPE:
  - 0x51/0x52/0x53 → store type, sum+=byte, idx=0 → DATA.
  - 0x55 → stay in TYPE, sum=0x55 (resync).
  - Any other byte → HUNT. No error, no count.
- DATA: store byte at idx, sum+=byte, idx++. When idx=7 is written → SUM.
- SUM:
  - byte == sum: on the following clk, load acc/gyro/angle per type plus temp, pulse the matching *_vld, go to HUNT.
  - byte != sum: on the following clk, pulse frame_err, increment err_cnt, leave fields untouched, go to HUNT.

Latency: outputs and pulses assert exactly 1 clk after the rx_valid of the checksum byte.

Timeout:
- Counter clears on every rx_valid and holds at 0 in HUNT.
- In TYPE/DATA/SUM it counts each cycle without rx_valid.
- On reaching TIMEOUT_CYC-1: go to HUNT, pulse timeout_err, increment err_cnt.

Boundary conditions:
- rx_valid in the expiry cycle: the byte wins; no timeout occurs and the byte is processed.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- frame_err and timeout_err never assert in the same cycle.
- A checksum byte equal to 0x55 is treated as a checksum, not as a header.
- After any frame end (good, bad or timeout) the next byte is evaluated in HUNT.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded.
- rx_valid held high for multiple cycles: each high cycle counts as a new byte (the source guarantees single-cycle strobes).
- busy rises the cycle after header acceptance and falls the cycle after the checksum or timeout.

Test Plan:
1. Send 55 51 10 00 20 00 30 00 40 0B 51 → 1 clk after the last byte: acc=0x0030_0020_0010, temp=0x0B40, acc_vld pulses once, err_cnt=0.
2. Send 55 52 01 00 FF FF 00 80 00 00 26 → gyro=0x8000_FFFF_0001, gyro_vld pulses, temp=0x0000. Repeat with checksum 27 → frame_err pulses, err_cnt=1, gyro unchanged, no gyro_vld.
3. Send 00 FF 55 55 52 then a valid gyro payload and checksum → parser resyncs on the second 0x55 and gyro_vld pulses. Send 55 54 → returns to HUNT with no error and err_cnt unchanged.
4. Send 55 51 02, then TIMEOUT_CYC idle cycles → timeout_err pulses once at expiry, busy=0, err_cnt+1. A following full frame decodes correctly. Repeat with the next byte landing exactly in the expiry cycle → no timeout.
5. Assert rst_n low after 5 bytes of a frame → all outputs 0 immediately. A following valid angle frame 55 53 … → angle_vld pulses with the correct words.
6. Send 300 bad-checksum frames → err_cnt stops at 255, frame_err pulses 300 times.
